// File: rtl/prefetch_sequencer.sv
// Instruction prefetch controller: fetches code words over the memory bus into a
// byte queue and drives the IP register controls so IP follows the queue head.
module prefetch_sequencer #(
    parameter int DEPTH = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cs,
    input  logic        load_new_ip,
    input  logic [15:0] new_ip,
    input  logic        q_pop,
    output logic [7:0]  q_byte,
    output logic        q_valid,
    output logic        ip_inc,
    output logic        ip_wr_en,
    output logic [15:0] ip_wr_val,
    output logic        mem_access,
    output logic [18:0] mem_address,
    input  logic        mem_ack,
    input  logic [15:0] mem_data
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ABORT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     fetch_ip_q, fetch_ip_d;
    logic            mem_access_q, mem_access_d;
    logic [18:0]     mem_address_q, mem_address_d;
    logic [7:0]      queue_q [DEPTH];
    logic [7:0]      queue_d [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;

    logic            pop_ok;
    logic            ack_push;
    logic            space_ok;
    logic [CW-1:0]   free_bytes;
    logic [CW-1:0]   need_bytes;
    logic [CW-1:0]   n_push;
    logic [19:0]     phys_addr;
    logic [PW-1:0]   tail_p1;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign q_valid     = (count_q != '0);
    assign q_byte      = queue_q[head_q];
    assign ip_inc      = q_pop & q_valid & ~load_new_ip;
    assign ip_wr_en    = load_new_ip;
    assign ip_wr_val   = new_ip;
    assign mem_access  = mem_access_q;
    assign mem_address = mem_address_q;

    assign pop_ok     = q_pop & q_valid & ~load_new_ip;
    assign free_bytes = CW'(DEPTH) - count_q;
    // An odd fetch_ip only consumes the high byte of the word, so one slot suffices.
    assign need_bytes = fetch_ip_q[0] ? CW'(1) : CW'(2);
    assign space_ok   = (free_bytes >= need_bytes);
    assign phys_addr  = {cs, 4'h0} + {4'h0, fetch_ip_q};
    assign ack_push   = (state_q == S_FETCH) & mem_ack & ~load_new_ip;
    assign tail_p1    = ptr_inc(tail_q);

    always_comb begin
        state_d       = state_q;
        fetch_ip_d    = fetch_ip_q;
        mem_access_d  = mem_access_q;
        mem_address_d = mem_address_q;
        head_d        = head_q;
        tail_d        = tail_q;
        n_push        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            queue_d[i] = queue_q[i];
        end

        case (state_q)
            S_IDLE: begin
                if (!load_new_ip && space_ok) begin
                    state_d       = S_FETCH;
                    mem_access_d  = 1'b1;
                    mem_address_d = phys_addr[19:1];
                end
            end
            S_FETCH: begin
                if (mem_ack) begin
                    state_d      = S_IDLE;
                    mem_access_d = 1'b0;
                end else if (load_new_ip) begin
                    // The bus cycle must still complete; its data will be dropped.
                    state_d = S_ABORT;
                end
            end
            S_ABORT: begin
                if (mem_ack) begin
                    state_d      = S_IDLE;
                    mem_access_d = 1'b0;
                end
            end
            default: begin
                state_d      = S_IDLE;
                mem_access_d = 1'b0;
            end
        endcase

        if (ack_push) begin
            if (fetch_ip_q[0]) begin
                queue_d[tail_q] = mem_data[15:8];
                tail_d          = tail_p1;
                fetch_ip_d      = fetch_ip_q + 16'd1;
                n_push          = CW'(1);
            end else begin
                queue_d[tail_q]  = mem_data[7:0];
                queue_d[tail_p1] = mem_data[15:8];
                tail_d           = ptr_inc(tail_p1);
                fetch_ip_d       = fetch_ip_q + 16'd2;
                n_push           = CW'(2);
            end
        end

        if (pop_ok) begin
            head_d = ptr_inc(head_q);
        end

        count_d = count_q + n_push - CW'(pop_ok);

        if (load_new_ip) begin
            fetch_ip_d = new_ip;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            fetch_ip_q    <= '0;
            mem_access_q  <= 1'b0;
            mem_address_q <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                queue_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            fetch_ip_q    <= fetch_ip_d;
            mem_access_q  <= mem_access_d;
            mem_address_q <= mem_address_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                queue_q[i] <= queue_d[i];
            end
        end
    end
endmodule

// File: tb/tb_prefetch_sequencer.sv
// Bench for prefetch_sequencer: directed scenarios plus a randomized run against a
// transaction-level model of the fetch queue and bus handshake.
module tb_prefetch_sequencer;
    localparam int DEPTH = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cs, new_ip, mem_data;
    logic        load_new_ip, q_pop, mem_ack;
    logic [7:0]  q_byte;
    logic        q_valid, ip_inc, ip_wr_en, mem_access;
    logic [15:0] ip_wr_val;
    logic [18:0] mem_address;

    prefetch_sequencer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .cs(cs), .load_new_ip(load_new_ip), .new_ip(new_ip),
        .q_pop(q_pop), .q_byte(q_byte), .q_valid(q_valid), .ip_inc(ip_inc),
        .ip_wr_en(ip_wr_en), .ip_wr_val(ip_wr_val), .mem_access(mem_access),
        .mem_address(mem_address), .mem_ack(mem_ack), .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // stimulus for the next cycle
    logic [15:0] t_cs, t_newip, t_data;
    logic        t_load, t_pop, t_ack;
    // observed outputs during the last stepped cycle
    logic        o_access, o_valid, o_inc, o_wr_en;
    logic [18:0] o_addr;
    logic [7:0]  o_byte;
    logic [15:0] o_wr_val;
    // model expectations for the same cycle
    logic        e_access, e_valid, e_inc;
    logic [18:0] e_addr;
    logic [7:0]  e_byte;

    // reference model: byte queue, fetch pointer, outstanding bus cycle
    logic [7:0]  mq[$];
    logic [15:0] m_ip;
    bit          m_busy, m_disc;
    logic [18:0] m_addr;

    task automatic clear_inputs();
        t_cs = 16'h0; t_newip = 16'h0; t_data = 16'h0;
        t_load = 1'b0; t_pop = 1'b0; t_ack = 1'b0;
    endtask

    task automatic model_clear();
        mq.delete();
        m_ip = 16'h0; m_busy = 1'b0; m_disc = 1'b0; m_addr = 19'h0;
    endtask

    // Applies t_* for one cycle (called at negedge), samples, then advances the model.
    task automatic step();
        logic [19:0] phys;
        int          sz;
        cs = t_cs; load_new_ip = t_load; new_ip = t_newip;
        q_pop = t_pop; mem_ack = t_ack; mem_data = t_data;
        #1;
        o_access = mem_access; o_addr = mem_address; o_valid = q_valid; o_byte = q_byte;
        o_inc = ip_inc; o_wr_en = ip_wr_en; o_wr_val = ip_wr_val;
        e_access = m_busy; e_addr = m_addr; e_valid = (mq.size() != 0);
        e_byte = e_valid ? mq[0] : 8'h00;
        e_inc = t_pop && e_valid && !t_load;
        @(posedge clk);
        sz = mq.size();
        if (t_load) begin
            mq.delete();
            m_ip = t_newip;
            if (m_busy && !t_ack) m_disc = 1'b1;
            else begin m_busy = 1'b0; m_disc = 1'b0; end
        end else begin
            if (t_pop && sz > 0) void'(mq.pop_front());
            if (m_busy) begin
                if (t_ack) begin
                    if (!m_disc) begin
                        if (m_ip[0]) begin
                            mq.push_back(t_data[15:8]);
                            m_ip = m_ip + 16'd1;
                        end else begin
                            mq.push_back(t_data[7:0]);
                            mq.push_back(t_data[15:8]);
                            m_ip = m_ip + 16'd2;
                        end
                    end
                    m_busy = 1'b0; m_disc = 1'b0;
                end
            end else if (DEPTH - sz >= (m_ip[0] ? 1 : 2)) begin
                m_busy = 1'b1;
                phys = {t_cs, 4'h0} + {4'h0, m_ip};
                m_addr = phys[19:1];
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        clear_inputs();
        cs = 16'h0; load_new_ip = 1'b0; new_ip = 16'h0; q_pop = 1'b0; mem_ack = 1'b0; mem_data = 16'h0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        clear_inputs();
        cs = 16'h0; load_new_ip = 1'b0; new_ip = 16'h0; q_pop = 1'b0; mem_ack = 1'b0; mem_data = 16'h0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (mem_access !== 1'b0) begin errors++; $display("FAIL reset_mem_access got %0b want 0", mem_access); end
        checks++; if (mem_address !== 19'h0) begin errors++; $display("FAIL reset_mem_address got %05h want 00000", mem_address); end
        checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL reset_q_valid got %0b want 0", q_valid); end
        checks++; if (q_byte !== 8'h00) begin errors++; $display("FAIL reset_q_byte got %02h want 00", q_byte); end
        checks++; if (ip_inc !== 1'b0 || ip_wr_en !== 1'b0) begin errors++; $display("FAIL reset_ip_ctl got inc=%0b wr_en=%0b want 0/0", ip_inc, ip_wr_en); end
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        step();
        step();
        checks++; if (o_access !== 1'b1) begin errors++; $display("FAIL reset_first_launch got %0b want 1", o_access); end
        #2 reset = 1'b1;
        #1;
        checks++; if (mem_access !== 1'b0) begin errors++; $display("FAIL reset_mid_fetch got %0b want 0", mem_access); end
        @(negedge clk);
    endtask

    task automatic test_branch_even();
        do_reset();
        t_cs = 16'hF000; t_load = 1'b1; t_newip = 16'hFFF0;
        step();
        checks++; if (o_wr_en !== 1'b1 || o_wr_val !== 16'hFFF0) begin errors++; $display("FAIL even_wr got en=%0b val=%04h want 1/fff0", o_wr_en, o_wr_val); end
        t_load = 1'b0;
        step();
        checks++; if (o_access !== 1'b0) begin errors++; $display("FAIL even_no_early_access got %0b want 0", o_access); end
        step();
        checks++; if (o_access !== 1'b1 || o_addr !== 19'h7FFF8) begin errors++; $display("FAIL even_launch got acc=%0b addr=%05h want 1/7fff8", o_access, o_addr); end
        t_ack = 1'b1; t_data = 16'h1234;
        step();
        t_ack = 1'b0; t_pop = 1'b1;
        step();
        checks++; if (o_valid !== 1'b1 || o_byte !== 8'h34 || o_inc !== 1'b1) begin errors++; $display("FAIL even_first_byte got v=%0b b=%02h inc=%0b want 1/34/1", o_valid, o_byte, o_inc); end
        step();
        checks++; if (o_byte !== 8'h12 || o_inc !== 1'b1) begin errors++; $display("FAIL even_second_byte got b=%02h inc=%0b want 12/1", o_byte, o_inc); end
        checks++; if (o_access !== 1'b1 || o_addr !== 19'h7FFF9) begin errors++; $display("FAIL even_next_launch got acc=%0b addr=%05h want 1/7fff9", o_access, o_addr); end
        t_pop = 1'b0;
    endtask

    task automatic test_branch_odd();
        do_reset();
        t_cs = 16'h0000; t_load = 1'b1; t_newip = 16'h0101;
        step();
        t_load = 1'b0;
        step();
        step();
        checks++; if (o_access !== 1'b1 || o_addr !== 19'h00080) begin errors++; $display("FAIL odd_launch got acc=%0b addr=%05h want 1/00080", o_access, o_addr); end
        t_ack = 1'b1; t_data = 16'hBBAA;
        step();
        t_ack = 1'b0; t_pop = 1'b1;
        step();
        checks++; if (o_valid !== 1'b1 || o_byte !== 8'hBB) begin errors++; $display("FAIL odd_byte got v=%0b b=%02h want 1/bb", o_valid, o_byte); end
        t_pop = 1'b0;
        step();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL odd_single_byte got v=%0b want 0", o_valid); end
        checks++; if (o_access !== 1'b1 || o_addr !== 19'h00081) begin errors++; $display("FAIL odd_next_launch got acc=%0b addr=%05h want 1/00081", o_access, o_addr); end
    endtask

    task automatic test_fill();
        int acks = 0;
        bit any_access = 1'b0;
        do_reset();
        t_load = 1'b1; t_newip = 16'h0000;
        step();
        t_load = 1'b0;
        for (int i = 0; i < 20; i++) begin
            t_ack = m_busy;
            t_data = 16'h1111 * 16'(i + 1);
            step();
            if (t_ack && o_access) acks++;
        end
        t_ack = 1'b0;
        checks++; if (acks !== 3) begin errors++; $display("FAIL fill_fetch_count got %0d want 3", acks); end
        checks++; if (o_access !== 1'b0 || o_valid !== 1'b1) begin errors++; $display("FAIL fill_full got acc=%0b v=%0b want 0/1", o_access, o_valid); end
        t_pop = 1'b1;
        step();
        t_pop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (o_access) any_access = 1'b1;
        end
        checks++; if (any_access !== 1'b0) begin errors++; $display("FAIL fill_one_pop_launch got 1 want 0"); end
        t_pop = 1'b1;
        step();
        t_pop = 1'b0;
        step();
        checks++; if (o_access !== 1'b0) begin errors++; $display("FAIL fill_launch_latency got %0b want 0", o_access); end
        step();
        checks++; if (o_access !== 1'b1 || o_addr !== 19'h00003) begin errors++; $display("FAIL fill_relaunch got acc=%0b addr=%05h want 1/00003", o_access, o_addr); end
    endtask

    task automatic test_abort();
        do_reset();
        t_load = 1'b1; t_newip = 16'h0000;
        step();
        t_load = 1'b0;
        step();
        step();
        checks++; if (o_access !== 1'b1) begin errors++; $display("FAIL abort_setup got %0b want 1", o_access); end
        t_load = 1'b1; t_newip = 16'h0200;
        step();
        t_load = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (o_access !== 1'b1) begin errors++; $display("FAIL abort_hold got %0b want 1", o_access); end
        end
        t_ack = 1'b1; t_data = 16'hDEAD;
        step();
        checks++; if (o_access !== 1'b1) begin errors++; $display("FAIL abort_ack_cycle got %0b want 1", o_access); end
        t_ack = 1'b0;
        step();
        checks++; if (o_valid !== 1'b0 || o_access !== 1'b0) begin errors++; $display("FAIL abort_discard got v=%0b acc=%0b want 0/0", o_valid, o_access); end
        step();
        checks++; if (o_access !== 1'b1 || o_addr !== 19'h00100) begin errors++; $display("FAIL abort_relaunch got acc=%0b addr=%05h want 1/00100", o_access, o_addr); end
    endtask

    task automatic test_wrap();
        do_reset();
        t_cs = 16'h1000; t_load = 1'b1; t_newip = 16'hFFFE;
        step();
        t_load = 1'b0;
        step();
        step();
        checks++; if (o_addr !== 19'h0FFFF) begin errors++; $display("FAIL wrap_launch got %05h want 0ffff", o_addr); end
        t_ack = 1'b1; t_data = 16'h5A5A;
        step();
        t_ack = 1'b0;
        step();
        step();
        checks++; if (o_access !== 1'b1 || o_addr !== 19'h08000) begin errors++; $display("FAIL wrap_next got acc=%0b addr=%05h want 1/08000", o_access, o_addr); end
    endtask

    task automatic test_flush_pop();
        do_reset();
        t_load = 1'b1; t_newip = 16'h0001;
        step();
        t_load = 1'b0;
        step();
        step();
        t_ack = 1'b1; t_data = 16'hAA55;
        step();
        t_ack = 1'b0;
        step();
        step();
        t_ack = 1'b1; t_data = 16'hCCBB;
        step();
        t_ack = 1'b0;
        t_load = 1'b1; t_pop = 1'b1; t_newip = 16'h0300;
        step();
        checks++; if (o_inc !== 1'b0 || o_wr_en !== 1'b1 || o_wr_val !== 16'h0300 || o_valid !== 1'b1) begin
            errors++; $display("FAIL flush_pop_ctl got inc=%0b en=%0b val=%04h v=%0b want 0/1/0300/1", o_inc, o_wr_en, o_wr_val, o_valid);
        end
        t_load = 1'b0; t_pop = 1'b0;
        step();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL flush_empty got %0b want 0", o_valid); end

        do_reset();
        t_load = 1'b1; t_newip = 16'h0000;
        step();
        t_load = 1'b0;
        step();
        step();
        t_ack = 1'b1; t_data = 16'h2211;
        step();
        t_ack = 1'b0;
        step();
        step();
        t_ack = 1'b1; t_data = 16'h4433; t_pop = 1'b1;
        step();
        checks++; if (o_byte !== 8'h11 || o_inc !== 1'b1) begin errors++; $display("FAIL pushpop_head got b=%02h inc=%0b want 11/1", o_byte, o_inc); end
        t_ack = 1'b0;
        step();
        checks++; if (o_valid !== 1'b1 || o_byte !== 8'h22) begin errors++; $display("FAIL pushpop_b0 got v=%0b b=%02h want 1/22", o_valid, o_byte); end
        step();
        checks++; if (o_valid !== 1'b1 || o_byte !== 8'h33) begin errors++; $display("FAIL pushpop_b1 got v=%0b b=%02h want 1/33", o_valid, o_byte); end
        step();
        checks++; if (o_valid !== 1'b1 || o_byte !== 8'h44) begin errors++; $display("FAIL pushpop_b2 got v=%0b b=%02h want 1/44", o_valid, o_byte); end
        t_pop = 1'b0;
        step();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL pushpop_count got v=%0b want 0", o_valid); end
    endtask

    task automatic test_random();
        int bad = 0;
        do_reset();
        t_cs = 16'($urandom); t_load = 1'b1; t_newip = 16'($urandom);
        step();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) t_cs = 16'($urandom);
            t_load  = ($urandom_range(0, 19) == 0);
            t_newip = 16'($urandom);
            t_pop   = ($urandom_range(0, 1) == 1);
            t_ack   = m_busy && ($urandom_range(0, 2) == 0);
            t_data  = 16'($urandom);
            step();
            checks++;
            if (o_access !== e_access || (e_access && o_addr !== e_addr)) begin
                errors++; bad++;
                if (bad < 10) $display("FAIL rand_bus cyc %0d got acc=%0b addr=%05h want %0b/%05h", i, o_access, o_addr, e_access, e_addr);
            end
            checks++;
            if (o_valid !== e_valid || (e_valid && o_byte !== e_byte)) begin
                errors++; bad++;
                if (bad < 10) $display("FAIL rand_queue cyc %0d got v=%0b b=%02h want %0b/%02h", i, o_valid, o_byte, e_valid, e_byte);
            end
            checks++;
            if (o_inc !== e_inc || o_wr_en !== t_load || o_wr_val !== t_newip) begin
                errors++; bad++;
                if (bad < 10) $display("FAIL rand_ip cyc %0d got inc=%0b en=%0b val=%04h want %0b/%0b/%04h", i, o_inc, o_wr_en, o_wr_val, e_inc, t_load, t_newip);
            end
        end
        t_ack = 1'b0; t_pop = 1'b0; t_load = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_branch_even();
        test_branch_odd();
        test_fill();
        test_abort();
        test_wrap();
        test_flush_pop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
